data_read_ctrl: RTL and testbench

DATA_READ_CTRL -- requirements
Module: data_read_ctrl

---
 rtl/data_read_pkg.sv | 16 +
 rtl/data_read_ctrl.sv | 131 +++++++++++++
 tb/tb_data_read_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/data_read_pkg.sv
// Shared capture-buffer sizing defaults and the capture FSM state encoding.
// No logic here; no latency and no backpressure.
package data_read_pkg;

  localparam int DEPTH_DEF  = 4096;
  localparam int ADDR_W_DEF = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_WAIT_TRIG,
    ST_POST,
    ST_DONE
  } state_t;

endpackage

// File: rtl/data_read_ctrl.sv
// Pre/post-trigger capture controller driving a circular sample buffer; write strobe is 1 cycle after the sample.
// No backpressure: every sample_valid seen in PRE/WAIT_TRIG/POST is written, and abort or rst drops it.
module data_read_ctrl
  import data_read_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              wr_clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              abort,
  input  logic              trig,
  input  logic [ADDR_W-1:0] pretrig,
  input  logic              sample_valid,
  input  logic              rd_release,
  output logic [ADDR_W-1:0] buf_wr_addr,
  output logic              buf_wr_en,
  output logic              busy,
  output logic              triggered,
  output logic              done,
  output logic [ADDR_W-1:0] start_addr
);

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_TOP = ADDR_W'(DEPTH - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, ptr_inc;
  logic [ADDR_W-1:0] pretrig_q, pretrig_d;
  logic [ADDR_W-1:0] start_q, start_d;
  logic [ADDR_W:0]   cnt_q, cnt_d, post_total;
  logic              accept;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;

  assign ptr_inc    = (wr_ptr_q == PTR_TOP) ? '0 : wr_ptr_q + 1'b1;
  // Post-trigger budget tops up the pre-trigger writes to exactly DEPTH.
  assign post_total = DEPTH_C - {1'b0, pretrig_q};

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    pretrig_d = pretrig_q;
    start_d   = start_q;
    cnt_d     = cnt_q;
    accept    = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (state_q == ST_DONE && rd_release) begin
          state_d = ST_IDLE;
        end else if (arm) begin
          wr_ptr_d  = '0;
          pretrig_d = pretrig;
          cnt_d     = {1'b0, pretrig};
          state_d   = (pretrig == '0) ? ST_WAIT_TRIG : ST_PRE;
        end
      end

      ST_PRE: begin
        if (sample_valid) begin
          accept   = 1'b1;
          wr_ptr_d = ptr_inc;
          cnt_d    = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) state_d = ST_WAIT_TRIG;
        end
      end

      ST_WAIT_TRIG: begin
        if (sample_valid) begin
          accept   = 1'b1;
          wr_ptr_d = ptr_inc;
        end
        if (trig) begin
          start_d = wr_ptr_q - pretrig_q;
          // A sample arriving with the trigger is the first post-trigger sample.
          cnt_d   = post_total - {{ADDR_W{1'b0}}, sample_valid};
          state_d = (sample_valid && post_total == CNT_ONE) ? ST_DONE : ST_POST;
        end
      end

      ST_POST: begin
        if (sample_valid) begin
          accept   = 1'b1;
          wr_ptr_d = ptr_inc;
          cnt_d    = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) state_d = ST_DONE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (abort) begin
      state_d  = ST_IDLE;
      accept   = 1'b0;
      wr_ptr_d = wr_ptr_q;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge wr_clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      wr_ptr_q  <= '0;
      pretrig_q <= '0;
      start_q   <= '0;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      pretrig_q <= pretrig_d;
      start_q   <= start_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= accept;
      if (accept) wr_addr_q <= wr_ptr_q;
    end
  end

  assign buf_wr_en   = wr_en_q;
  assign buf_wr_addr = wr_addr_q;
  assign start_addr  = start_q;
  assign busy        = (state_q == ST_PRE) || (state_q == ST_WAIT_TRIG) || (state_q == ST_POST);
  assign triggered   = (state_q == ST_POST) || (state_q == ST_DONE);
  assign done        = (state_q == ST_DONE);

endmodule

// File: tb/tb_data_read_ctrl.sv
// Scoreboard bench for data_read_ctrl: stimulus queues expected write addresses, a monitor pops them on each strobe.
module tb_data_read_ctrl;

  logic        wr_clk = 1'b0;
  logic        rst = 1'b1;
  logic        arm = 1'b0, abort = 1'b0, trig = 1'b0, sample_valid = 1'b0, rd_release = 1'b0;
  logic [11:0] pretrig = '0;
  logic [11:0] buf_wr_addr, start_addr;
  logic        buf_wr_en, busy, triggered, done;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          exp_ptr = 0;
  logic [11:0] exp_q[$];

  always #5 wr_clk = ~wr_clk;

  data_read_ctrl #(.DEPTH(4096), .ADDR_W(12)) dut (
    .wr_clk      (wr_clk),
    .rst         (rst),
    .arm         (arm),
    .abort       (abort),
    .trig        (trig),
    .pretrig     (pretrig),
    .sample_valid(sample_valid),
    .rd_release  (rd_release),
    .buf_wr_addr (buf_wr_addr),
    .buf_wr_en   (buf_wr_en),
    .busy        (busy),
    .triggered   (triggered),
    .done        (done),
    .start_addr  (start_addr)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic a, input logic ab, input logic t, input logic sv, input logic rel);
    arm = a; abort = ab; trig = t; sample_valid = sv; rd_release = rel;
    @(posedge wr_clk);
    #1;
    arm = 1'b0; abort = 1'b0; trig = 1'b0; sample_valid = 1'b0; rd_release = 1'b0;
  endtask

  // One sample the controller must write at the next expected address.
  task automatic smp(input logic a, input logic t);
    exp_q.push_back(exp_ptr[11:0]);
    exp_ptr = (exp_ptr + 1) % 4096;
    step(a, 1'b0, t, 1'b1, 1'b0);
  endtask

  task automatic smp_n(input int n);
    for (int i = 0; i < n; i++) smp(1'b0, 1'b0);
  endtask

  task automatic status(input string tag, input int b, input int tr, input int d);
    chk({tag, "_busy"}, int'(busy), b);
    chk({tag, "_triggered"}, int'(triggered), tr);
    chk({tag, "_done"}, int'(done), d);
  endtask

  task automatic do_arm(input logic [11:0] p);
    pretrig = p;
    exp_ptr = 0;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  always @(negedge wr_clk) begin
    if (buf_wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: strobe at addr %0d, expected no write", buf_wr_addr);
      end else begin
        chk("wr_addr", int'(buf_wr_addr), int'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    repeat (3) @(posedge wr_clk);
    #1;
    rst = 1'b0;
    status("reset", 0, 0, 0);
    chk("reset_wr_en", int'(buf_wr_en), 0);
    chk("reset_start", int'(start_addr), 0);

    // pretrig=100: 100 PRE + 50 WAIT_TRIG, trigger at pointer 150, 3996 post writes.
    do_arm(12'd100);
    pretrig = 12'd7;
    status("a_pre", 1, 0, 0);
    smp_n(100);
    smp_n(50);
    status("a_wait", 1, 0, 0);
    smp(1'b0, 1'b1);
    status("a_post", 1, 1, 0);
    smp_n(3995);
    status("a_done", 0, 1, 1);
    chk("a_start", int'(start_addr), 50);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    status("a_release", 0, 0, 0);

    // pretrig=0: trigger with the first sample, addresses 0..4095.
    do_arm(12'd0);
    status("b_wait", 1, 0, 0);
    smp(1'b0, 1'b1);
    smp_n(4094);
    status("b_last", 1, 1, 0);
    smp(1'b0, 1'b0);
    status("b_done", 0, 1, 1);
    chk("b_start", int'(start_addr), 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // pretrig=10 with trigger pulsed on sample 5 of PRE, then abort in POST.
    do_arm(12'd10);
    smp_n(4);
    smp(1'b0, 1'b1);
    smp_n(4);
    status("c_pre9", 1, 0, 0);
    smp(1'b0, 1'b0);
    status("c_wait", 1, 0, 0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    status("c_post", 1, 1, 0);
    smp_n(2000);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    status("c_abort", 0, 0, 0);
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    do_arm(12'd3);
    smp_n(3);
    status("c_rearm", 1, 0, 0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    status("c_abort_arm", 0, 0, 0);

    // pretrig=1000, 4000 WAIT_TRIG samples so the trigger lands at pointer 904 after wrapping.
    do_arm(12'd1000);
    pretrig = 12'd5;
    smp_n(1000);
    status("d_wait", 1, 0, 0);
    smp_n(2000);
    smp(1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    smp_n(1999);
    chk("d_ptr_model", exp_ptr, 904);
    smp(1'b0, 1'b1);
    smp_n(3094);
    status("d_last", 1, 1, 0);
    smp(1'b0, 1'b0);
    status("d_done", 0, 1, 1);
    chk("d_start", int'(start_addr), 4000);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    status("d_release_wins", 0, 0, 0);

    // Reset in the middle of WAIT_TRIG discards the capture.
    do_arm(12'd5);
    smp_n(15);
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    rst = 1'b0;
    status("e_reset", 0, 0, 0);
    chk("e_wr_en", int'(buf_wr_en), 0);
    chk("e_wr_addr", int'(buf_wr_addr), 0);
    chk("e_start", int'(start_addr), 0);
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
